// File: rtl/sampler_pkg.sv
// Shared constants, controller state encoding and target clamping for the
// multi-channel ADC sampler.
package sampler_pkg;

   localparam int unsigned DATA_W = 14;
   localparam int unsigned DEPTH  = 1024;
   localparam int unsigned DEC_W  = 8;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HALT
   } state_t;

   function automatic int unsigned clamp_target(input int unsigned target,
                                                input int unsigned depth);
      return (target > depth) ? depth : target;
   endfunction

endpackage

// File: rtl/sampler_ch_core.sv
// One capture channel: private sample buffer, write pointer, done flag and
// registered readout.
module sampler_ch_core #(
   parameter int unsigned DATA_W = sampler_pkg::DATA_W,
   parameter int unsigned DEPTH  = sampler_pkg::DEPTH,
   parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              run,
   input  logic              strobe,
   input  logic              cont,
   input  logic [IDX_W:0]    target,
   input  logic [DATA_W-1:0] data_in,
   input  logic [IDX_W-1:0]  read_index,
   output logic [DATA_W-1:0] data_out,
   output logic              done
);
   import sampler_pkg::*;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [IDX_W:0]    wr_ptr;
   logic [IDX_W:0]    tgt_q;
   logic [IDX_W:0]    ptr_inc;
   logic              wr_en;

   assign ptr_inc = wr_ptr + (IDX_W+1)'(1);
   // A zero target never writes; a finished single-shot channel stops writing.
   assign wr_en   = run && strobe && !clear && (tgt_q != '0) && (cont || !done);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         tgt_q  <= '0;
         done   <= 1'b0;
      end else if (clear) begin
         wr_ptr <= '0;
         tgt_q  <= target;
         done   <= 1'b0;
      end else if (run) begin
         if (tgt_q == '0) begin
            done <= 1'b1;
         end else if (wr_en) begin
            if (ptr_inc == tgt_q) begin
               done   <= 1'b1;
               wr_ptr <= cont ? '0 : ptr_inc;
            end else begin
               wr_ptr <= ptr_inc;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[IDX_W-1:0]] <= data_in;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) data_out <= '0;
      else        data_out <= mem[read_index];
   end

endmodule

// File: rtl/multi_ch_sampler.sv
// N-channel ADC sampler: shared start/stop controller and decimation counter
// driving one capture core per channel.
module multi_ch_sampler #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned DATA_W = sampler_pkg::DATA_W,
   parameter int unsigned DEPTH  = sampler_pkg::DEPTH,
   parameter int unsigned IDX_W  = $clog2(DEPTH),
   parameter int unsigned DEC_W  = sampler_pkg::DEC_W
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         stop,
   input  logic                         mode,
   input  logic [DEC_W-1:0]             decim,
   input  logic [NUM_CH*(IDX_W+1)-1:0]  sample_target,
   input  logic [NUM_CH*DATA_W-1:0]     data_in,
   input  logic [IDX_W-1:0]             read_index,
   output logic [NUM_CH*DATA_W-1:0]     data_out,
   output logic [NUM_CH-1:0]            done,
   output logic                         busy
);
   import sampler_pkg::*;

   state_t           state;
   logic             mode_q;
   logic [DEC_W-1:0] decim_q;
   logic [DEC_W-1:0] dec_cnt;
   logic             run;
   logic             strobe;

   assign run    = (state == RUN);
   assign strobe = run && (dec_cnt == decim_q);

   // start has priority over stop and over the single-shot completion exit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         busy    <= 1'b0;
         mode_q  <= 1'b0;
         decim_q <= '0;
         dec_cnt <= '0;
      end else if (start) begin
         state   <= RUN;
         busy    <= 1'b1;
         mode_q  <= mode;
         decim_q <= decim;
         dec_cnt <= '0;
      end else if (run) begin
         dec_cnt <= strobe ? '0 : dec_cnt + DEC_W'(1);
         if (stop || (!mode_q && (&done))) begin
            state <= HALT;
            busy  <= 1'b0;
         end
      end
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      logic [IDX_W:0] tgt_clamped;

      assign tgt_clamped = (IDX_W+1)'(clamp_target(
                              32'(sample_target[k*(IDX_W+1) +: IDX_W+1]), DEPTH));

      sampler_ch_core #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH),
         .IDX_W  (IDX_W)
      ) u_core (
         .clk        (clk),
         .reset      (reset),
         .clear      (start),
         .run        (run),
         .strobe     (strobe),
         .cont       (mode_q),
         .target     (tgt_clamped),
         .data_in    (data_in[k*DATA_W +: DATA_W]),
         .read_index (read_index),
         .data_out   (data_out[k*DATA_W +: DATA_W]),
         .done       (done[k])
      );
   end

endmodule

// File: tb/tb_multi_ch_sampler.sv
// Directed bench for multi_ch_sampler: single-shot, decimation, continuous,
// restart/clamp, async reset and read-during-write.
module tb_multi_ch_sampler;

   localparam int NUM_CH = 4;
   localparam int DATA_W = 14;
   localparam int DEPTH  = 1024;
   localparam int IDX_W  = 10;
   localparam int DEC_W  = 8;
   localparam int TW     = IDX_W + 1;

   logic                     clk = 1'b0;
   logic                     reset = 1'b0;
   logic                     start = 1'b0;
   logic                     stop = 1'b0;
   logic                     mode = 1'b0;
   logic [DEC_W-1:0]         decim = '0;
   logic [NUM_CH*TW-1:0]     sample_target = '0;
   logic [NUM_CH*DATA_W-1:0] data_in = '0;
   logic [IDX_W-1:0]         read_index = '0;
   logic [NUM_CH*DATA_W-1:0] data_out;
   logic [NUM_CH-1:0]        done;
   logic                     busy;

   int n_checks = 0;
   int n_pass   = 0;
   int base     = 0;
   int cnt      = 0;

   multi_ch_sampler #(
      .NUM_CH (NUM_CH),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W),
      .DEC_W  (DEC_W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .stop          (stop),
      .mode          (mode),
      .decim         (decim),
      .sample_target (sample_target),
      .data_in       (data_in),
      .read_index    (read_index),
      .data_out      (data_out),
      .done          (done),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   // Channel k sample n: channel number in the top bits, base+n in the low 12.
   function automatic logic [DATA_W-1:0] ramp(int k, int n);
      return DATA_W'((k << 12) | ((base + n) & 'hFFF));
   endfunction

   function automatic logic [NUM_CH*DATA_W-1:0] ramp_all(int n);
      logic [NUM_CH*DATA_W-1:0] v;
      v = '0;
      for (int k = 0; k < NUM_CH; k++) v[k*DATA_W +: DATA_W] = ramp(k, n);
      return v;
   endfunction

   function automatic logic [DATA_W-1:0] ch(int k);
      return data_out[k*DATA_W +: DATA_W];
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cnt++;
      data_in = ramp_all(cnt);
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   // After this, the sample captured on the i-th RUN edge (i >= 1) is ramp(i-1).
   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
      cnt = 0;
      data_in = ramp_all(0);
   endtask

   task automatic set_targets(input int t0, input int t1, input int t2, input int t3);
      sample_target = {TW'(t3), TW'(t2), TW'(t1), TW'(t0)};
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cont_exp [4];
      cont_exp = '{8, 9, 6, 7};
      data_in = ramp_all(0);

      // Reset state
      steps(2);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_dout", data_out, 0);
      reset = 1'b1;
      step();

      // Single-shot basics
      base = 0; mode = 1'b0; decim = 0;
      set_targets(4, 8, 0, 1024);
      pulse_start();
      check("ss_busy_start", busy, 1);
      check("ss_done_start", done, 0);
      step();
      check("ss_done_e1", done, 4'b0100);
      steps(2);
      check("ss_done_e3", done, 4'b0100);
      step();
      check("ss_done_e4", done, 4'b0101);
      steps(4);
      check("ss_done_e8", done, 4'b0111);
      steps(1015);
      check("ss_done_e1023", done, 4'b0111);
      step();
      check("ss_done_e1024", done, 4'b1111);
      check("ss_busy_e1024", busy, 1);
      step();
      check("ss_halt_busy", busy, 0);
      for (int i = 0; i < 4; i++) begin
         read_index = IDX_W'(i);
         step();
         check("ss_rd_ch0", ch(0), ramp(0, i));
      end
      read_index = IDX_W'(1023);
      step();
      check("ss_rd_ch3_last", ch(3), ramp(3, 1023));
      read_index = IDX_W'(7);
      step();
      check("ss_rd_ch1_7", ch(1), ramp(1, 7));

      // Decimation: strobes on RUN edges 4,8,12,16,20
      base = 100; decim = 3;
      set_targets(5, 5, 5, 5);
      pulse_start();
      steps(19);
      check("dec_done_e19", done, 0);
      step();
      check("dec_done_e20", done, 4'hF);
      step();
      check("dec_halt_busy", busy, 0);
      for (int i = 0; i < 5; i++) begin
         read_index = IDX_W'(i);
         step();
         check("dec_rd_ch2", ch(2), ramp(2, 4*i + 3));
      end

      // Continuous mode: 10 strobes into a 4-entry circle
      base = 200; mode = 1'b1; decim = 0;
      set_targets(4, 4, 4, 4);
      pulse_start();
      steps(3);
      check("cont_done_e3", done, 0);
      step();
      check("cont_done_e4", done, 4'hF);
      steps(5);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("cont_stop_busy", busy, 0);
      check("cont_stop_done", done, 4'hF);
      for (int i = 0; i < 4; i++) begin
         read_index = IDX_W'(i);
         step();
         check("cont_rd", data_out, ramp_all(cont_exp[i]));
      end

      // Restart, start+stop collision, clamp of 1500 to 1024
      base = 300; mode = 1'b0;
      set_targets(1500, 2, 2, 2);
      pulse_start();
      steps(2);
      check("rs_done_e2", done, 4'b1110);
      step();
      pulse_start();
      check("rs_restart_done", done, 0);
      check("rs_restart_busy", busy, 1);
      steps(2);
      check("rs_done_again", done, 4'b1110);
      stop = 1'b1;
      pulse_start();
      stop = 1'b0;
      check("rs_collide_busy", busy, 1);
      check("rs_collide_done", done, 0);
      steps(1023);
      check("rs_clamp_e1023", done, 4'b1110);
      step();
      check("rs_clamp_e1024", done, 4'hF);
      read_index = IDX_W'(1023);
      step();
      check("rs_clamp_rd", ch(0), ramp(0, 1023));

      // Asynchronous reset between clock edges
      base = 500;
      set_targets(8, 8, 8, 8);
      read_index = '0;
      pulse_start();
      steps(3);
      check("ar_pre_dout", data_out, ramp_all(0));
      check("ar_pre_busy", busy, 1);
      #2;
      reset = 1'b0;
      #1;
      check("ar_done", done, 0);
      check("ar_busy", busy, 0);
      check("ar_dout", data_out, 0);
      @(negedge clk);
      reset = 1'b1;
      base = 600;
      pulse_start();
      steps(8);
      check("ar_recap_done", done, 4'hF);
      for (int i = 0; i < 8; i += 3) begin
         read_index = IDX_W'(i);
         step();
         check("ar_recap_rd", data_out, ramp_all(i));
      end

      // Read-during-write at index 0
      base = 700; mode = 1'b1;
      set_targets(4, 4, 4, 4);
      read_index = '0;
      pulse_start();
      steps(4);
      step();
      check("rdw_old", data_out, ramp_all(0));
      step();
      check("rdw_new", data_out, ramp_all(4));
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("rdw_stop_busy", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
